// File: rtl/tt_sar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_sar_pkg
// Description : Shared types and helpers for the SAR ADC controller:
//               FSM state encoding and conversion latency helper.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_sar_pkg;

    localparam int unsigned c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        SETTLE = 3'd2,
        DECIDE = 3'd3,
        DONE   = 3'd4
    } sar_state_e;

    // Cycles from the accepted start edge to the done pulse.
    // n_conv is 1 for a plain conversion and 4 when averaging is built in.
    function automatic int unsigned sar_latency(
        input int unsigned n_bits,
        input int unsigned sample_cycles,
        input int unsigned settle_cycles,
        input int unsigned n_conv
    );
        return n_conv * (sample_cycles + n_bits * (settle_cycles + 1)) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : tt_sync_2ff
// Description : Two-flop synchroniser for asynchronous single-bit returns
//               from analog macros. Resets to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // First stage may go metastable; second stage gives it a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/tt_sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tt_sar_adc_ctrl
// Description : Successive-approximation controller. Drives track/hold and
//               the cap-DAC code, reads the synchronised comparator and
//               resolves one bit per step, MSB first.
//               Build option SAR_AVG4_EN: four back-to-back conversions per
//               start, result is the truncated mean.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_sar_adc_ctrl
    import tt_sar_pkg::*;
#(
    parameter int unsigned N_BITS        = 8,
    parameter int unsigned SAMPLE_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cmp_in,
    output logic              sample_o,
    output logic [N_BITS-1:0] dac_code,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] result
);

    localparam int unsigned c_CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam int unsigned c_IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [c_CNT_W-1:0] c_SAMPLE_LOAD = c_CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LOAD = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_MSB     = c_IDX_W'(N_BITS - 1);
    localparam logic [N_BITS-1:0]  c_DAC_MSB     = N_BITS'(1) << (N_BITS - 1);

    sar_state_e          r_state;
    sar_state_e          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [N_BITS-1:0]   r_dac;
    logic [N_BITS-1:0]   r_result;
    logic [N_BITS-1:0]   w_code;
    logic [N_BITS-1:0]   w_trial;
    logic                w_cmp_s;
    logic                w_cnt_zero;
    logic                w_last_bit;
    logic                w_run_last;

`ifdef SAR_AVG4_EN
    logic [N_BITS+1:0]   r_acc;
    logic [N_BITS+1:0]   w_acc_sum;
    logic [1:0]          r_conv;

    assign w_acc_sum  = r_acc + {2'b00, w_code};
    assign w_run_last = (r_conv == 2'd3);
`else
    assign w_run_last = 1'b1;
`endif

    tt_sync_2ff u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (cmp_in),
        .o_q   (w_cmp_s)
    );

    assign w_cnt_zero = (r_cnt == '0);
    assign w_last_bit = (r_idx == '0);
    assign dac_code   = r_dac;
    assign result     = r_result;

    // Resolved code for the current bit, and the code with the next trial bit raised.
    always_comb begin
        w_code        = r_dac;
        w_code[r_idx] = w_cmp_s;
        w_trial       = w_code;
        if (!w_last_bit) begin
            w_trial[r_idx - c_IDX_W'(1)] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and Moore outputs; abort wins over every running transition.
    always_comb begin
        w_state_nxt = r_state;
        sample_o    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = SAMPLE;
            end
            SAMPLE: begin
                sample_o = 1'b1;
                busy     = 1'b1;
                if (abort)           w_state_nxt = IDLE;
                else if (w_cnt_zero) w_state_nxt = SETTLE;
            end
            SETTLE: begin
                busy = 1'b1;
                if (abort)           w_state_nxt = IDLE;
                else if (w_cnt_zero) w_state_nxt = DECIDE;
            end
            DECIDE: begin
                busy = 1'b1;
                if (abort)            w_state_nxt = IDLE;
                else if (!w_last_bit) w_state_nxt = SETTLE;
                else if (w_run_last)  w_state_nxt = DONE;
                else                  w_state_nxt = SAMPLE;
            end
            DONE: begin
                done = 1'b1;
                if (start) w_state_nxt = SAMPLE;
                else       w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Phase counter, bit index, SAR register and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_dac    <= '0;
            r_result <= '0;
`ifdef SAR_AVG4_EN
            r_acc    <= '0;
            r_conv   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_dac <= '0;
                        r_idx <= c_IDX_MSB;
                        r_cnt <= c_SAMPLE_LOAD;
`ifdef SAR_AVG4_EN
                        r_acc  <= '0;
                        r_conv <= '0;
`endif
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        r_dac <= '0;
                    end else if (w_cnt_zero) begin
                        // Track phase over: raise the MSB trial bit.
                        r_dac <= c_DAC_MSB;
                        r_cnt <= c_SETTLE_LOAD;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        r_dac <= '0;
                    end else if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                DECIDE: begin
                    if (abort) begin
                        r_dac <= '0;
`ifdef SAR_AVG4_EN
                        r_acc <= '0;
`endif
                    end else if (!w_last_bit) begin
                        r_dac <= w_trial;
                        r_idx <= r_idx - c_IDX_W'(1);
                        r_cnt <= c_SETTLE_LOAD;
                    end else begin
`ifdef SAR_AVG4_EN
                        r_acc <= w_acc_sum;
                        if (w_run_last) begin
                            r_dac    <= w_code;
                            r_result <= w_acc_sum[N_BITS+1:2];
                        end else begin
                            // Straight into the next track phase, no done in between.
                            r_conv <= r_conv + 2'd1;
                            r_dac  <= '0;
                            r_idx  <= c_IDX_MSB;
                            r_cnt  <= c_SAMPLE_LOAD;
                        end
`else
                        r_dac    <= w_code;
                        r_result <= w_code;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tt_sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_sar_adc_ctrl
// Description : Self-checking bench for tt_sar_adc_ctrl. An ideal comparator
//               (cmp_in = Vin >= dac_code) stands in for the analog macro;
//               expected codes come from an arithmetic binary-search model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_sar_adc_ctrl;

    localparam int N  = 8;
    localparam int SC = 4;
    localparam int ST = 3;
`ifdef SAR_AVG4_EN
    localparam int NCONV = 4;
`else
    localparam int NCONV = 1;
`endif
    localparam int CONV_CYC = SC + N * (ST + 1);
    localparam int LAT      = NCONV * CONV_CYC + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       cmp_in;
    logic       sample_o;
    logic [7:0] dac_code;
    logic       busy;
    logic       done;
    logic [7:0] result;

    logic [7:0] vin = 8'h00;
    logic       cmp_rand_en = 1'b0;
    logic       cmp_rand = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] vin;
        logic [7:0] exp_result;
    } vec_t;

    vec_t vecs[6];

    // Ideal comparator unless the reset phase is injecting noise.
    assign cmp_in = cmp_rand_en ? cmp_rand : (vin >= dac_code);

    always #5 clk = ~clk;

    tt_sar_adc_ctrl #(
        .N_BITS        (N),
        .SAMPLE_CYCLES (SC),
        .SETTLE_CYCLES (ST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .cmp_in   (cmp_in),
        .sample_o (sample_o),
        .dac_code (dac_code),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Binary search on plain integers: largest code not above v.
    function automatic logic [7:0] ideal_sar(input logic [7:0] v);
        int code = 0;
        for (int b = N - 1; b >= 0; b--) begin
            if (int'(v) >= code + (1 << b)) code += (1 << b);
        end
        return 8'(code);
    endfunction

    // The DAC codes tried during the search, MSB trial in the top byte.
    function automatic logic [63:0] ideal_trials(input logic [7:0] v);
        int code = 0;
        logic [63:0] t = '0;
        for (int k = 0; k < N; k++) begin
            int w = 1 << (N - 1 - k);
            t[63 - 8*k -: 8] = 8'(code + w);
            if (int'(v) >= code + w) code += w;
        end
        return t;
    endfunction

    // Mean of the conversions run for one start; odd conversions see v0, even v1.
    function automatic logic [7:0] expected_result(input logic [7:0] v0, input logic [7:0] v1);
        int sum = 0;
        for (int k = 1; k <= NCONV; k++) begin
            sum += int'(ideal_sar((k % 2 == 1) ? v0 : v1));
        end
        return 8'(sum / NCONV);
    endfunction

    // One start pulse, then observe a fixed window; optional second start at restart_at.
    task automatic run_conv(
        input  logic [7:0]  v0,
        input  logic [7:0]  v1,
        input  int          restart_at,
        output int          done_cyc,
        output int          n_done,
        output int          busy_cnt,
        output int          samp_cnt,
        output logic [63:0] trials,
        output logic [7:0]  res
    );
        int   conv_idx = 0;
        logic prev_samp = 1'b0;
        done_cyc = 0; n_done = 0; busy_cnt = 0; samp_cnt = 0; trials = '0; res = '0;
        @(negedge clk);
        vin   = v0;
        start = 1'b1;
        for (int c = 1; c <= LAT + 4; c++) begin
            @(negedge clk);
            if (sample_o && !prev_samp) begin
                conv_idx++;
                vin = conv_idx[0] ? v0 : v1;
            end
            prev_samp = sample_o;
            if (sample_o) samp_cnt++;
            if (busy) busy_cnt++;
            if (done) begin
                n_done++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    res      = result;
                end
            end
            if (conv_idx == 1 && c >= SC + 1 && ((c - SC - 1) % (ST + 1)) == 0 && ((c - SC - 1) / (ST + 1)) < N)
                trials[63 - 8*((c - SC - 1) / (ST + 1)) -: 8] = dac_code;
            start = (c == restart_at);
        end
        start = 1'b0;
    endtask

    initial begin
        int          dc, nd, bc, sc, d1, d2, found;
        logic [63:0] tr;
        logic [7:0]  rs, r1, r2, rv;

        vecs[0] = '{8'hA5, 8'hA5};
        vecs[1] = '{8'h00, 8'h00};
        vecs[2] = '{8'hFF, 8'hFF};
        vecs[3] = '{8'h01, 8'h01};
        vecs[4] = '{8'h80, 8'h80};
        vecs[5] = '{8'h7F, 8'h7F};

        // Reset held with random inputs: every output stays at zero.
        cmp_rand_en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("reset_outputs", 64'({sample_o, dac_code, busy, done, result}), 64'(0));
            start    = 1'($urandom_range(0, 1));
            abort    = 1'($urandom_range(0, 1));
            cmp_rand = 1'($urandom_range(0, 1));
        end
        start = 1'b0; abort = 1'b0; cmp_rand_en = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("idle_after_reset", 64'({sample_o, busy, done}), 64'(0));
        end

        // Directed vectors, including both code extremes.
        for (int i = 0; i < 6; i++) begin
            run_conv(vecs[i].vin, vecs[i].vin, 0, dc, nd, bc, sc, tr, rs);
            check("vec_result",   64'(rs), 64'(vecs[i].exp_result));
            check("vec_done_cyc", 64'(dc), 64'(LAT));
            check("vec_n_done",   64'(nd), 64'(1));
            check("vec_busy_cyc", 64'(bc), 64'(LAT - 1));
            check("vec_samp_cyc", 64'(sc), 64'(SC * NCONV));
            check("vec_trials",   tr, ideal_trials(vecs[i].vin));
        end

        // Random input levels against the model.
        for (int i = 0; i < 8; i++) begin
            rv = 8'($urandom_range(0, 255));
            run_conv(rv, rv, 0, dc, nd, bc, sc, tr, rs);
            check("rand_result",   64'(rs), 64'(expected_result(rv, rv)));
            check("rand_done_cyc", 64'(dc), 64'(LAT));
        end

        // A second start while busy is dropped.
        run_conv(8'h3C, 8'h3C, 10, dc, nd, bc, sc, tr, rs);
        check("restart_n_done",   64'(nd), 64'(1));
        check("restart_done_cyc", 64'(dc), 64'(LAT));
        check("restart_result",   64'(rs), 64'(8'h3C));

        // Input alternating between conversions (averaging build takes the mean).
        run_conv(8'h40, 8'h43, 0, dc, nd, bc, sc, tr, rs);
        check("alt_result",   64'(rs), 64'(expected_result(8'h40, 8'h43)));
        check("alt_done_cyc", 64'(dc), 64'(LAT));
        check("alt_n_done",   64'(nd), 64'(1));

        // start held high: back-to-back conversions, Vin steps 0x10 -> 0x20.
        @(negedge clk);
        vin = 8'h10; start = 1'b1;
        d1 = 0; d2 = 0; r1 = '0; r2 = '0;
        for (int c = 1; c <= 2 * LAT + 4; c++) begin
            @(negedge clk);
            if (done) begin
                if (d1 == 0) begin
                    d1 = c; r1 = result; vin = 8'h20;
                end else if (d2 == 0) begin
                    d2 = c; r2 = result; start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b_done1_cyc", 64'(d1), 64'(LAT));
        check("b2b_done2_cyc", 64'(d2), 64'(2 * LAT));
        check("b2b_result1",   64'(r1), 64'(8'h10));
        check("b2b_result2",   64'(r2), 64'(8'h20));

        // Abort during the DECIDE of bit 4: back to IDLE, no done, old result kept.
        run_conv(8'hA5, 8'hA5, 0, dc, nd, bc, sc, tr, rs);
        check("abort_pre_result", 64'(rs), 64'(8'hA5));
        @(negedge clk);
        vin = 8'h3C; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 20) begin
                check("abort_busy_before", 64'(busy), 64'(1));
                abort = 1'b1;
            end
        end
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy",   64'(busy),     64'(0));
        check("abort_dac",    64'(dac_code), 64'(0));
        check("abort_sample", 64'(sample_o), 64'(0));
        nd = 0;
        for (int c = 1; c <= LAT + 4; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_no_done", 64'(nd),     64'(0));
        check("abort_result",  64'(result), 64'(8'hA5));

        // abort while idle has no effect on an accepted start.
        @(negedge clk);
        vin = 8'h5A; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("idle_abort_busy", 64'(busy), 64'(1));
        found = 0; rs = '0;
        for (int c = 2; c <= LAT + 4; c++) begin
            @(negedge clk);
            if (done && found == 0) begin
                found = 1; rs = result;
            end
        end
        check("idle_abort_done",   64'(found), 64'(1));
        check("idle_abort_result", 64'(rs),    64'(8'h5A));

        // Asynchronous reset mid-conversion clears everything at once.
        @(negedge clk);
        vin = 8'h77; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_result", 64'(result),   64'(0));
        check("rst_mid_dac",    64'(dac_code), 64'(0));
        check("rst_mid_busy",   64'(busy),     64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_mid_idle", 64'({sample_o, busy, done}), 64'(0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_sar_adc_ctrl.md
Name: tt_sar_adc_ctrl

Overview:
Digital successive-approximation controller that drives the project's analog front end. It issues the track/hold control and the capacitor-DAC code on the way out, and reads back the analog comparator decision. It sits between the tile's digital pins (start/result) and the analog macro.
- Analog macro is the responder (comparator + cap DAC).
- This block is the initiator: binary search, one bit per step, MSB first.

Parameters:
N_BITS, 8, conversion resolution and width of dac_code/result.
SAMPLE_CYCLES, 4, cycles sample_o is held high (track phase), >=1.
SETTLE_CYCLES, 3, cycles per bit between a DAC update and the comparator decision, >=2 (covers the 2-flop synchroniser).

Ports:
clk  in  1  single system clock
rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  conversion request, level-sampled in IDLE and DONE
abort  in  1  synchronous abort of a running conversion
cmp_in  in  1  raw comparator output from analog macro (async); 1 = Vin >= Vdac
sample_o  out  1  track switch enable to analog macro
dac_code  out  N_BITS  cap-DAC code to analog macro
busy  out  1  high from SAMPLE through last DECIDE
done  out  1  one-cycle pulse, result valid
result  out  N_BITS  last completed conversion, held until next done

Behaviour:
- Reset values: sample_o=0, dac_code=0, busy=0, done=0, result=0, state=IDLE, cmp synchroniser=0.
- cmp_in passes through a 2-flop synchroniser (cmp_s) before any use.
- States: IDLE, SAMPLE, SETTLE, DECIDE, DONE.
- IDLE: start=1 -> SAMPLE. Actions: busy=1, sample_o=1, dac_code=0, bit index i=N_BITS-1, counter loaded.
- SAMPLE: lasts exactly SAMPLE_CYCLES cycles. On exit: sample_o=0, dac_code[i]=1 (trial bit) -> SETTLE.
- SETTLE: lasts exactly SETTLE_CYCLES cycles -> DECIDE.
- DECIDE (1 cycle): if cmp_s=0, clear dac_code[i]; the bit is kept if cmp_s=1.
  - If i>0: i--, set dac_code[i], -> SETTLE.
  - If i=0: -> DONE.
- DONE (1 cycle): done=1, busy=0, result<=dac_code. dac_code holds its final value until the next SAMPLE.
  - start=1 here -> SAMPLE directly (back-to-back).
  - Otherwise -> IDLE.
- Latency: start seen at cycle 0 -> done high at cycle SAMPLE_CYCLES + N_BITS*(SETTLE_CYCLES+1) + 1 (37 with defaults).
  - busy is high for all preceding cycles of the conversion.
- start while busy: ignored, not queued.
- abort=1 in SAMPLE/SETTLE/DECIDE: next state IDLE, sample_o=0, dac_code=0, busy=0, no done pulse, result unchanged. abort has priority over all transitions. abort in IDLE/DONE: no effect.
- rst_n low mid-conversion: immediate return to all reset values, including result=0.
- Code extremes: all cmp_s=1 -> all ones; all cmp_s=0 -> zero. No wrap or overflow is possible in the non-averaging path.

Optional Feature:
SAR_AVG4_EN
- Defined:
  - Each accepted start runs 4 consecutive conversions.
  - Each conversion adds to an N_BITS+2 accumulator; the accumulator clears at start.
  - Sequence between conversions: SAMPLE re-entered after each DECIDE at i=0, with no DONE in between.
  - busy stays high throughout; done pulses once after the 4th conversion.
  - result = accumulator[N_BITS+1:2] (truncating divide by 4).
  - Latency: 4*(SAMPLE_CYCLES + N_BITS*(SETTLE_CYCLES+1)) + 1.
  - abort discards the accumulator.
- Undefined: single conversion exactly as above; no accumulator logic is present.

Decomposition:
- Package tt_sar_pkg holds:
  - state enum type (IDLE, SAMPLE, SETTLE, DECIDE, DONE)
  - localparam state encoding width
  - latency constant helper (function of N_BITS, SAMPLE_CYCLES, SETTLE_CYCLES)
- One sub-module: tt_sync_2ff (2-flop synchroniser for cmp_in, with reset value 0). It is reusable for other async analog returns.
- FSM, counters and SAR register live in the top block.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0; release -> remains IDLE while start=0.
- Behavioural comparator model cmp_in=(0xA5 >= dac_code), single start pulse -> sample_o high cycles 1-4, busy high 36 cycles, done at cycle 37, result=0xA5.
- Extremes: Vin=0x00 -> result 0x00; Vin=0xFF -> result 0xFF. dac_code trial sequence for 0x00 is 0x80, 0x40, ..., 0x01.
- Handshake: start pulsed again at cycle 10 -> ignored, single done. start held high -> done pulses every 37 cycles; results match a Vin stepping 0x10 -> 0x20.
- Abort/reset mid-op: abort during bit 4 DECIDE -> IDLE next cycle, no done, result keeps prior 0xA5. rst_n low at cycle 20 -> result=0, dac_code=0 immediately.
- SAR_AVG4_EN: model Vin alternating 0x40, 0x43, 0x40, 0x43 -> single done at cycle 145, result=0x41.
